lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store unit that executes RV32I load (LB/LH/LW/LBU/LHU) and store (SB/SH/SW) operations. It accepts requests from the execute stage and drives a word-wide data-memory bus. It returns aligned, sign- or zero-extended load data to writeback. It is the memory-side counterpart of the instruction decoder: decode produces OpLoad/OpStore plus funct3, and this block carries them out on the bus.

## Interface
Parameters:
- RegWidth, 32, data and address width (fixed at 32; other values are unsupported).
- RegAddrWidth, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nRst  in  1  asynchronous active-low reset.
- req_valid  in  1  execute stage presents an operation.
- req_ready  out  1  block accepts the operation (high only in IDLE).
- req_store  in  1  1 = store (OpStore), 0 = load (OpLoad).
- req_funct3  in  3  OpF3LB..OpF3LHU / OpF3SB..OpF3SW encoding.
- req_addr  in  32  byte address (rs1 + imm).
- req_wdata  in  32  rs2 value for stores.
- req_rd  in  RegAddrWidth  load destination register.
- mem_valid  out  1  bus request valid.
- mem_ready  in  1  bus accepts request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address ({req_addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables (all zero for reads).
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data word.
- wb_valid  out  1  single-cycle load result pulse.
- wb_rd  out  RegAddrWidth  destination register.
- wb_data  out  32  extended load data.
- err_valid  out  1  single-cycle fault pulse (see Configuration).
- err_addr  out  32  faulting byte address.
- err_store  out  1  1 = store fault, 0 = load fault.

## Operation
- FSM has three states: IDLE, REQ, RDWAIT.
  - IDLE: req_ready=1. On req_valid, the block latches store, funct3, addr[1:0], rd and the formatted bus fields, then goes to REQ.
  - REQ: mem_valid=1, with all bus fields held stable. When mem_ready=1, a store returns to IDLE and a load goes to RDWAIT.
  - RDWAIT: on mem_rvalid, the block registers the extracted data into wb_data, pulses wb_valid on the next cycle, and returns to IDLE.
- Store formatting:
  - SB: wdata = {4{b[7:0]}}, wstrb = 4'b0001<<addr[1:0].
  - SH: wdata = {2{h[15:0]}}, wstrb = 4'b0011<<{addr[1],1'b0}.
  - SW: wdata = data, wstrb = 4'b1111.
- Load extraction:
  - Byte lane is rdata[8*addr[1:0] +: 8]; half lane is rdata[16*addr[1] +: 16].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes rdata unchanged.
- Only one operation is outstanding at a time. mem_rvalid outside RDWAIT is ignored.
- Reset mid-operation: the FSM returns to IDLE immediately and any outstanding bus read is abandoned. A late mem_rvalid after reset is ignored.

## Timing
- Reset values: req_ready=1, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, wb_valid=0, wb_rd=0, wb_data=0, err_valid=0, err_addr=0, err_store=0.
- Request accepted in cycle N. mem_valid is high from cycle N+1 until the cycle where mem_ready=1 (inclusive).
- Load latency: if mem_ready=1 at N+1 and mem_rvalid=1 at N+2, wb_valid=1 at N+3. The minimum load latency is therefore 3 cycles.
- Store latency: the block is back in IDLE with req_ready=1 at N+2 when mem_ready=1 at N+1. Back-to-back stores therefore issue every 2 cycles.
- Bus rule: once asserted, mem_valid and all bus fields hold until mem_ready. Stalls of any length are allowed.
- wb_valid and err_valid are exactly one cycle wide. They are never asserted together.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - These requests are faults: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 of 3'b011, 3'b110 or 3'b111; store funct3 >= 3'b011.
  - A fault is accepted in IDLE but makes no bus access. err_valid pulses at N+1 with err_addr=req_addr and err_store=req_store. The FSM stays in IDLE, and req_ready is 0 only during the pulse cycle.
- LSU_ALIGN_CHECK_EN undefined:
  - err_* are tied to 0.
  - Misaligned halves and words use lane shifts with the low address bits truncated: half lane by addr[1], word lane ignores addr[1:0].
  - Illegal funct3 executes as LW/SW.

## Test plan
- LB at 0x1003, rdata=0x80FF_1234 -> wb_data=0xFFFF_FF80, mem_addr=0x1000, wb_valid at N+3.
- LHU at 0x2002, rdata=0xBEEF_0000 -> wb_data=0x0000_BEEF. LH on the same request -> wb_data=0xFFFF_BEEF.
- SB at 0x3001, data=0x0000_00A5 -> mem_wdata=0xA5A5_A5A5, mem_wstrb=4'b0010, mem_we=1, no wb_valid.
- SW with mem_ready held low 5 cycles -> mem_valid and fields stable for 6 cycles, req_ready=0 throughout.
- LW at 0x4002 with LSU_ALIGN_CHECK_EN -> err_valid at N+1, err_addr=0x4002, err_store=0, mem_valid never asserted.
- nRst low while in RDWAIT, then mem_rvalid=1 after reset release -> wb_valid stays 0, all outputs at reset values.

Source files
------------

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit: runs one LB/LH/LW/LBU/LHU/SB/SH/SW at a time on a word-wide data bus.
// Define LSU_ALIGN_CHECK_EN to fault misaligned accesses and illegal funct3 instead of executing them.
module lsu_mem_port #(
    parameter int RegWidth     = 32,
    parameter int RegAddrWidth = 5
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_store,
    input  logic [2:0]              req_funct3,
    input  logic [RegWidth-1:0]     req_addr,
    input  logic [RegWidth-1:0]     req_wdata,
    input  logic [RegAddrWidth-1:0] req_rd,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    mem_we,
    output logic [RegWidth-1:0]     mem_addr,
    output logic [RegWidth-1:0]     mem_wdata,
    output logic [3:0]              mem_wstrb,
    input  logic                    mem_rvalid,
    input  logic [RegWidth-1:0]     mem_rdata,
    output logic                    wb_valid,
    output logic [RegAddrWidth-1:0] wb_rd,
    output logic [RegWidth-1:0]     wb_data,
    output logic                    err_valid,
    output logic [RegWidth-1:0]     err_addr,
    output logic                    err_store
);

    typedef enum logic [1:0] {IDLE, REQ, RDWAIT} state_t;

    state_t                  state;
    logic [2:0]              funct3_q;
    logic [1:0]              addr_lo_q;
    logic [RegAddrWidth-1:0] rd_q;

    logic                    fault;
    logic [RegWidth-1:0]     fmt_wdata;
    logic [3:0]              fmt_wstrb;
    logic [7:0]              byte_lane;
    logic [15:0]             half_lane;
    logic [RegWidth-1:0]     load_data;

    // The error pulse cycle is the only time IDLE refuses a new request.
    assign req_ready = (state == IDLE) && !err_valid;

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        fault = 1'b0;
        if (req_store) begin
            case (req_funct3)
                3'b000:  fault = 1'b0;
                3'b001:  fault = req_addr[0];
                3'b010:  fault = |req_addr[1:0];
                default: fault = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: fault = 1'b0;
                3'b001, 3'b101: fault = req_addr[0];
                3'b010:         fault = |req_addr[1:0];
                default:        fault = 1'b1;
            endcase
        end
    end
`else
    assign fault = 1'b0;
`endif

    // Lane replication lets memory pick the addressed bytes purely from the strobes.
    always_comb begin
        fmt_wdata = req_wdata;
        fmt_wstrb = 4'b1111;
        case (req_funct3)
            3'b000: begin
                fmt_wdata = {4{req_wdata[7:0]}};
                fmt_wstrb = 4'b0001 << req_addr[1:0];
            end
            3'b001: begin
                fmt_wdata = {2{req_wdata[15:0]}};
                fmt_wstrb = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        byte_lane = mem_rdata[{addr_lo_q, 3'b000} +: 8];
        half_lane = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
        load_data = mem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_data = {24'b0, byte_lane};
            3'b101:  load_data = {16'b0, half_lane};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
            rd_q      <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_store <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            err_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        if (fault) begin
                            err_valid <= 1'b1;
                            err_addr  <= req_addr;
                            err_store <= req_store;
                        end else begin
                            state     <= REQ;
                            funct3_q  <= req_funct3;
                            addr_lo_q <= req_addr[1:0];
                            rd_q      <= req_rd;
                            mem_valid <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= {req_addr[RegWidth-1:2], 2'b00};
                            mem_wdata <= req_store ? fmt_wdata : '0;
                            mem_wstrb <= req_store ? fmt_wstrb : 4'b0000;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= mem_we ? IDLE : RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (mem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= load_data;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: a byte-level model queues expected bus, writeback and fault
// responses; a monitor pops and compares them while a randomized memory responder drives the bus.
module tb_lsu_mem_port;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_valid;
    logic [31:0] err_addr;
    logic        err_store;

    lsu_mem_port #(.RegWidth(32), .RegAddrWidth(5)) dut (
        .clk(clk), .nRst(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_valid(err_valid), .err_addr(err_addr), .err_store(err_store)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        store;
    } err_t;

    bus_t        busq[$];
    wb_t         wbq[$];
    err_t        errq[$];
    logic [31:0] rdq[$];

    int   vectors = 0;
    int   miscompares = 0;

    // Responder modes, written only by the main stimulus process.
    logic fast_bus;
    logic no_resp;
    int   stall_cycles;
    int   late_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got unexpected event, expected none", name);
    endtask

    function automatic int access_size(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic is_fault(input logic st, input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_ALIGN_CHECK_EN
        logic legal;
        int   sz;
        sz = access_size(st, f3);
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || ((addr % sz) != 0);
`else
        return (st && 1'b0) || (f3 != f3) || (addr != addr);
`endif
    endfunction

    // Pushes every response the request should produce, then presents it for one accepted cycle.
    task automatic apply_stimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata);
        int          w;
        int          sz;
        int          off;
        bus_t        b;
        logic [31:0] mask;
        logic [31:0] val;
        w = 0;
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) flag_fail("req_ready_timeout");
        sz  = access_size(st, f3);
        off = (sz == 4) ? 0 : (sz == 2) ? int'(addr & 32'd2) : int'(addr & 32'd3);
        if (is_fault(st, f3, addr)) begin
            errq.push_back('{addr: addr, store: st});
        end else begin
            b.addr = addr & ~32'd3;
            if (st) begin
                b.we    = 1'b1;
                b.wdata = (sz == 1) ? {24'b0, wdata[7:0]} * 32'h0101_0101 :
                          (sz == 2) ? {16'b0, wdata[15:0]} * 32'h0001_0001 : wdata;
                b.wstrb = 4'(((1 << sz) - 1) << off);
            end else begin
                b.we    = 1'b0;
                b.wdata = 32'h0;
                b.wstrb = 4'h0;
                mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
                val  = (rdata >> (8 * off)) & mask;
                if ((f3 == 3'd0 || f3 == 3'd1) && sz < 4 && val[8*sz-1]) val = val | ~mask;
                wbq.push_back('{rd: rd, data: val});
                rdq.push_back(rdata);
            end
            busq.push_back(b);
        end
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_req_ready"}, req_ready, 1'b1);
        check_output({tag, "_mem_valid"}, mem_valid, 1'b0);
        check_output({tag, "_mem_we"}, mem_we, 1'b0);
        check_output({tag, "_mem_addr"}, mem_addr, 32'h0);
        check_output({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check_output({tag, "_mem_wstrb"}, mem_wstrb, 4'h0);
        check_output({tag, "_wb_valid"}, wb_valid, 1'b0);
        check_output({tag, "_wb_rd"}, wb_rd, 5'h0);
        check_output({tag, "_wb_data"}, wb_data, 32'h0);
        check_output({tag, "_err_valid"}, err_valid, 1'b0);
        check_output({tag, "_err_addr"}, err_addr, 32'h0);
        check_output({tag, "_err_store"}, err_store, 1'b0);
    endtask

    // Memory responder: random ready stalls, random read latency, stray rvalid when no read is pending.
    initial begin
        int   rd_wait;
        int   held;
        int   late_seen;
        logic hs_read;
        rd_wait = -1;
        held = 0;
        late_seen = 0;
        hs_read = 1'b0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                rd_wait = -1;
                hs_read = 1'b0;
                held = 0;
                mem_ready = 1'b0;
            end else begin
                if (hs_read) rd_wait = fast_bus ? 0 : $urandom_range(0, 2);
                if (late_cnt != late_seen) begin
                    late_seen  = late_cnt;
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                end else if (rd_wait == 0 && !no_resp) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
                    rd_wait    = -1;
                end else if (rd_wait > 0) begin
                    rd_wait--;
                    mem_rdata = $urandom;
                end else if (rd_wait < 0 && !fast_bus && $urandom_range(0, 7) == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                end
                if (!mem_valid) begin
                    held = 0;
                    mem_ready = fast_bus ? 1'b1 : 1'($urandom_range(0, 1));
                end else if (stall_cycles > 0) begin
                    mem_ready = (held >= stall_cycles);
                    held++;
                end else begin
                    mem_ready = fast_bus ? 1'b1 : ($urandom_range(0, 2) == 0);
                end
                hs_read = mem_valid && mem_ready && !mem_we;
            end
        end
    end

    // Monitor: checks each new bus request, its hold stability, and every wb/err pulse.
    initial begin
        bus_t snap;
        bus_t e;
        wb_t  w;
        err_t r;
        logic prev_valid;
        prev_valid = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (mem_valid && !prev_valid) begin
                    snap = {mem_we, mem_addr, mem_wdata, mem_wstrb};
                    if (busq.size() == 0) flag_fail("bus_unexpected");
                    else begin
                        e = busq.pop_front();
                        check_output("bus_we", mem_we, e.we);
                        check_output("bus_addr", mem_addr, e.addr);
                        check_output("bus_wstrb", mem_wstrb, e.wstrb);
                        if (e.we) check_output("bus_wdata", mem_wdata, e.wdata);
                    end
                end else if (mem_valid) begin
                    check_output("bus_hold", {mem_we, mem_addr, mem_wdata, mem_wstrb}, snap);
                end
                prev_valid = mem_valid;
                if (wb_valid) begin
                    if (wbq.size() == 0) flag_fail("wb_unexpected");
                    else begin
                        w = wbq.pop_front();
                        check_output("wb_rd", wb_rd, w.rd);
                        check_output("wb_data", wb_data, w.data);
                    end
                end
                if (err_valid) begin
                    if (errq.size() == 0) flag_fail("err_unexpected");
                    else begin
                        r = errq.pop_front();
                        check_output("err_addr", err_addr, r.addr);
                        check_output("err_store", err_store, r.store);
                    end
                end
                if (wb_valid && err_valid) flag_fail("wb_err_overlap");
            end
        end
    end

    initial begin
        int          lat;
        int          hi;
        int          w;
        logic        st;
        logic [2:0]  f3;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_rd = 5'd0;
        fast_bus = 1'b1;
        no_resp = 1'b0;
        stall_cycles = 0;
        late_cnt = 0;
        repeat (3) @(negedge clk);
        check_reset_values("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("after_reset");

        // LB from the top byte lane, with minimum latency on a zero-wait bus.
        apply_stimulus(1'b0, 3'd0, 32'h1003, 32'h0, 5'd7, 32'h80FF_1234);
        lat = 1;
        while (!wb_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_output("lb_latency", lat, 3);
        apply_stimulus(1'b0, 3'd5, 32'h2002, 32'h0, 5'd8, 32'hBEEF_0000);
        apply_stimulus(1'b0, 3'd1, 32'h2002, 32'h0, 5'd9, 32'hBEEF_0000);
        apply_stimulus(1'b1, 3'd0, 32'h3001, 32'h0000_00A5, 5'd0, 32'h0);

        // SW with mem_ready held low for five cycles.
        fast_bus = 1'b0;
        stall_cycles = 5;
        apply_stimulus(1'b1, 3'd2, 32'h6000, 32'hCAFE_F00D, 5'd0, 32'h0);
        hi = 0;
        while (mem_valid && hi < 50) begin
            check_output("stall_req_ready", req_ready, 1'b0);
            hi++;
            @(negedge clk);
        end
        check_output("stall_valid_cycles", hi, 6);
        stall_cycles = 0;

`ifdef LSU_ALIGN_CHECK_EN
        fast_bus = 1'b1;
        apply_stimulus(1'b0, 3'd2, 32'h4002, 32'h0, 5'd3, 32'h0);
        check_output("fault_err_valid", err_valid, 1'b1);
        check_output("fault_err_addr", err_addr, 32'h4002);
        check_output("fault_err_store", err_store, 1'b0);
        check_output("fault_mem_valid", mem_valid, 1'b0);
        check_output("fault_req_ready", req_ready, 1'b0);
        @(negedge clk);
        check_output("fault_pulse_end", err_valid, 1'b0);
        check_output("fault_ready_back", req_ready, 1'b1);
        fast_bus = 1'b0;
`endif

        for (int i = 0; i < 250; i++) begin
            st = 1'($urandom_range(0, 1));
            if (st) f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            else f3 = 3'($urandom_range(0, 7));
            apply_stimulus(st, f3, $urandom, $urandom, 5'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset while a load waits in RDWAIT, then a late rvalid after release.
        w = 0;
        while ((busq.size() != 0 || wbq.size() != 0 || errq.size() != 0) && w < 500) begin
            @(negedge clk);
            w++;
        end
        fast_bus = 1'b1;
        no_resp = 1'b1;
        apply_stimulus(1'b0, 3'd2, 32'h5000, 32'h0, 5'd12, 32'h1234_5678);
        repeat (3) @(negedge clk);
        check_output("rdwait_busy", {req_ready, mem_valid}, 2'b00);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("mid_op_reset");
        wbq.delete();
        rdq.delete();
        no_resp = 1'b0;
        rst_n = 1'b1;
        late_cnt = late_cnt + 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("late_rvalid_wb", wb_valid, 1'b0);
        end
        check_reset_values("post_late_rvalid");

        fast_bus = 1'b0;
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)), $urandom & ~32'd3,
                           $urandom, 5'($urandom), $urandom);
        end
        w = 0;
        while ((busq.size() != 0 || wbq.size() != 0 || errq.size() != 0) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check_output("drain_bus", busq.size(), 0);
        check_output("drain_wb", wbq.size(), 0);
        check_output("drain_err", errq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
